// File: rtl/uart_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctl_pkg
// Purpose  : State encodings and constants shared by the console UART controller
// Revision : 1.0
// ============================================================================
package uart_ctl_pkg;

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_REQ    = 2'd1,
        T_SETTLE = 2'd2,
        T_BUSY   = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_WAIT = 2'd2,
        R_CAP  = 2'd3
    } rx_state_t;

    // Consecutive full-and-pending cycles tolerated before flagging overflow
    localparam int STALL_LIMIT = 255;

endpackage
`default_nettype wire

// File: rtl/uart_ctl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctl_fifo
// Purpose  : DEPTH x 8 circular receive FIFO with registered head storage
// Revision : 1.0
// ============================================================================
module uart_ctl_fifo
    import uart_ctl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign full    = (count == FULL_COUNT);
    assign valid   = (count != '0);
    assign head    = mem[rd_ptr];

    // Storage is cleared too so the head output reads zero out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_ctl.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctl
// Purpose  : Two-port TX arbiter/sequencer and autonomous RX poller for the console UART
// Revision : 1.0
// ============================================================================
module uart_ctl
    import uart_ctl_pkg::*;
#(
    parameter int RX_DEPTH   = 4,
    parameter int TX_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_req,
    input  logic [7:0] a_data,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [7:0] b_data,
    output logic       b_ack,
    output logic       tx_req,
    output logic [7:0] tx_data,
    input  logic       tx_ack,
    input  logic       tx_empty,
    output logic       rx_req,
    input  logic       rx_ack,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic       tx_busy,
    output logic       tx_err,
    output logic       rx_ovf
);

    localparam int              CW           = $clog2(RX_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_COUNT  = RX_DEPTH[CW-1:0];
    localparam logic [15:0]     TIMEOUT_LAST = 16'(TX_TIMEOUT - 1);
    localparam logic [7:0]      STALL_MAX    = 8'(STALL_LIMIT);

    // ------------------------------------------------------------------
    // Transmit arbitration and sequencing
    // ------------------------------------------------------------------
    tx_state_t   tx_state;
    logic        gnt_b;
    logic        rr_b;
    logic        pick_b;
    logic [15:0] tx_cnt;

    // Port B wins only when A is silent or the round-robin pointer favours B
    assign pick_b  = b_req && (!a_req || rr_b);
    assign a_ack   = (tx_state == T_REQ) && tx_ack && !gnt_b;
    assign b_ack   = (tx_state == T_REQ) && tx_ack &&  gnt_b;
    assign tx_busy = (tx_state != T_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= T_IDLE;
            tx_req   <= 1'b0;
            tx_data  <= 8'h00;
            gnt_b    <= 1'b0;
            rr_b     <= 1'b0;
            tx_cnt   <= '0;
            tx_err   <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (a_req || b_req) begin
                        gnt_b    <= pick_b;
                        rr_b     <= !pick_b;
                        tx_data  <= pick_b ? b_data : a_data;
                        tx_req   <= 1'b1;
                        tx_state <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (tx_ack) begin
                        tx_req   <= 1'b0;
                        tx_state <= T_SETTLE;
                    end
                end
                T_SETTLE: begin
                    // tx_empty still reflects the previous byte this cycle
                    tx_cnt   <= '0;
                    tx_state <= T_BUSY;
                end
                T_BUSY: begin
                    if (tx_empty) begin
                        tx_state <= T_IDLE;
                    end else if (tx_cnt == TIMEOUT_LAST) begin
                        tx_err   <= 1'b1;
                        tx_state <= T_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive polling into the FIFO
    // ------------------------------------------------------------------
    rx_state_t       rx_state;
    logic            fifo_full;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      stall_cnt;
    logic            push;

    assign push = (rx_state == R_CAP);

    // A slot is implicitly reserved from R_REQ to R_CAP: only one byte is ever in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= R_IDLE;
            rx_req   <= 1'b0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (!rx_empty && (fifo_count < DEPTH_COUNT)) begin
                        rx_req   <= 1'b1;
                        rx_state <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (rx_ack) begin
                        rx_req   <= 1'b0;
                        rx_state <= R_WAIT;
                    end
                end
                R_WAIT:  rx_state <= R_CAP;
                R_CAP:   rx_state <= R_IDLE;
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 8'h00;
            rx_ovf    <= 1'b0;
        end else if (!fifo_full) begin
            stall_cnt <= 8'h00;
        end else if (!rx_empty) begin
            if (stall_cnt == STALL_MAX) begin
                rx_ovf <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    uart_ctl_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (rx_data),
        .pop       (rd_ready),
        .full      (fifo_full),
        .valid     (rd_valid),
        .count     (fifo_count),
        .head      (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_ctl
// Purpose  : Directed self-checking bench for uart_ctl with a behavioural UART
// Revision : 1.0
// ============================================================================
module tb_uart_ctl;

    localparam int RX_DEPTH   = 4;
    localparam int TX_TIMEOUT = 20;
    localparam int DRAIN      = 12;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       a_req = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       a_ack;
    logic       b_req = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_ack;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack = 1'b0;
    logic       tx_empty = 1'b1;
    logic       rx_req;
    logic       rx_ack = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready = 1'b0;
    logic       tx_busy;
    logic       tx_err;
    logic       rx_ovf;

    uart_ctl #(
        .RX_DEPTH   (RX_DEPTH),
        .TX_TIMEOUT (TX_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_req    (a_req),
        .a_data   (a_data),
        .a_ack    (a_ack),
        .b_req    (b_req),
        .b_data   (b_data),
        .b_ack    (b_ack),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .tx_empty (tx_empty),
        .rx_req   (rx_req),
        .rx_ack   (rx_ack),
        .rx_empty (rx_empty),
        .rx_data  (rx_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .tx_busy  (tx_busy),
        .tx_err   (tx_err),
        .rx_ovf   (rx_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural UART, updated just after each rising edge
    // ------------------------------------------------------------------
    logic       stuck = 1'b0;
    int         drain = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];

    always @(posedge clk) begin
        #1;
        if (tx_ack) begin
            tx_ack   = 1'b0;
            tx_empty = 1'b0;
            drain    = DRAIN;
        end else if (tx_req) begin
            tx_ack = 1'b1;
            tx_log.push_back(tx_data);
        end else if (drain > 0) begin
            drain--;
        end else if (!stuck) begin
            tx_empty = 1'b1;
        end

        if (rx_ack) begin
            rx_ack = 1'b0;
        end else if (rx_req && rx_q.size() > 0) begin
            rx_ack  = 1'b1;
            rx_data = rx_q.pop_front();
        end
        rx_empty = (rx_q.size() == 0);
    end

    // ------------------------------------------------------------------
    // Output monitors, sampled on the falling edge
    // ------------------------------------------------------------------
    int         a_ack_cnt = 0;
    int         b_ack_cnt = 0;
    int         a_run = 0;
    int         b_run = 0;
    int         max_run = 0;
    logic [7:0] rd_log[$];

    always @(negedge clk) begin
        if (a_ack) begin a_ack_cnt++; a_run++; end else a_run = 0;
        if (b_ack) begin b_ack_cnt++; b_run++; end else b_run = 0;
        if (a_run > max_run) max_run = a_run;
        if (b_run > max_run) max_run = b_run;
        if (rd_valid && rd_ready) rd_log.push_back(rd_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       a_req;
        logic [7:0] a_data;
        logic       b_req;
        logic [7:0] b_data;
        logic [7:0] exp_data;
        int         exp_a;
        int         exp_b;
    } tx_vec_t;

    tx_vec_t vecs[9];

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 rd_ready = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_req"},   tx_req,   0);
        check({tag, "_tx_data"},  tx_data,  0);
        check({tag, "_a_ack"},    a_ack,    0);
        check({tag, "_b_ack"},    b_ack,    0);
        check({tag, "_rx_req"},   rx_req,   0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"},  rd_data,  0);
        check({tag, "_tx_busy"},  tx_busy,  0);
        check({tag, "_tx_err"},   tx_err,   0);
        check({tag, "_rx_ovf"},   rx_ovf,   0);
    endtask

    task automatic run_tx(input tx_vec_t v, input string tag);
        int         a0;
        int         b0;
        int         n0;
        logic       done;
        logic       seen;
        logic [7:0] got;
        @(negedge clk);
        a0 = a_ack_cnt;
        b0 = b_ack_cnt;
        n0 = tx_log.size();
        a_req = v.a_req; a_data = v.a_data;
        b_req = v.b_req; b_data = v.b_data;
        done = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                a_req = 1'b0;
                b_req = 1'b0;
                seen  = 1'b1;
            end else if (seen && !tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(negedge clk);
        got = (tx_log.size() > n0) ? tx_log[n0] : 8'hxx;
        check({tag, "_done"},  done, 1);
        check({tag, "_data"},  got, v.exp_data);
        check({tag, "_a_ack"}, a_ack_cnt - a0, v.exp_a);
        check({tag, "_b_ack"}, b_ack_cnt - b0, v.exp_b);
    endtask

    initial begin
        int         n0;
        int         ai;
        int         bi;
        logic       done;
        logic [7:0] stream[23];
        logic [7:0] exp_c[6];
        logic [7:0] got;
        tx_vec_t    v;

        // Round-robin pointer starts at A; each grant flips it to the other side
        vecs[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 8'h41, 1, 0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h42, 8'h42, 0, 1};
        vecs[2] = '{1'b1, 8'h10, 1'b1, 8'h20, 8'h10, 1, 0};
        vecs[3] = '{1'b1, 8'h11, 1'b1, 8'h21, 8'h21, 0, 1};
        vecs[4] = '{1'b1, 8'h12, 1'b1, 8'h22, 8'h12, 1, 0};
        vecs[5] = '{1'b1, 8'h13, 1'b1, 8'h23, 8'h23, 0, 1};
        vecs[6] = '{1'b1, 8'h7F, 1'b0, 8'h00, 8'h7F, 1, 0};
        vecs[7] = '{1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, 0, 1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 8'h80, 8'h80, 0, 1};

        exp_c = '{8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};

        stream[0] = 8'h53; stream[1] = 8'h54; stream[2] = 8'h41;
        stream[3] = 8'h52; stream[4] = 8'h54; stream[5] = 8'h0D;
        for (int i = 6; i < 23; i++) stream[i] = 8'(8'h30 + i);

        // Reset values, checked before any clock edge
        #1 reset_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single transactions and arbitration table
        for (int i = 0; i < 9; i++) run_tx(vecs[i], $sformatf("vec%0d", i));

        // Continuous contention: grants must alternate A,B,A,B,A,B
        @(negedge clk);
        n0 = tx_log.size();
        ai = 0; bi = 0; done = 1'b0;
        a_req = 1'b1; a_data = 8'hA1;
        b_req = 1'b1; b_data = 8'hB1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (a_ack) begin
                ai++;
                if (ai == 3) a_req = 1'b0; else a_data = 8'(8'hA1 + ai);
            end
            if (b_ack) begin
                bi++;
                if (bi == 3) b_req = 1'b0; else b_data = 8'(8'hB1 + bi);
            end
            if (ai == 3 && bi == 3 && !tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        check("cont_done", done, 1);
        check("cont_count", tx_log.size() - n0, 6);
        for (int i = 0; i < 6; i++) begin
            got = (tx_log.size() > n0 + i) ? tx_log[n0 + i] : 8'hxx;
            check($sformatf("cont_byte%0d", i), got, exp_c[i]);
        end

        // RX drain of a 23-byte stream with the consumer always ready
        set_ready(1'b1);
        n0 = rd_log.size();
        for (int i = 0; i < 23; i++) rx_q.push_back(stream[i]);
        for (int c = 0; c < 2000 && rd_log.size() < n0 + 23; c++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("drain_count", rd_log.size() - n0, 23);
        for (int i = 0; i < 23; i++) begin
            got = (rd_log.size() > n0 + i) ? rd_log[n0 + i] : 8'hxx;
            check($sformatf("drain_byte%0d", i), got, stream[i]);
        end

        // FIFO full: exactly RX_DEPTH bytes taken, the rest left in the UART
        set_ready(1'b0);
        n0 = rd_log.size();
        for (int i = 0; i < 6; i++) rx_q.push_back(8'(8'h61 + i));
        repeat (60) @(negedge clk);
        check("full_rd_valid", rd_valid, 1);
        check("full_head", rd_data, 8'h61);
        check("full_left_in_uart", rx_q.size(), 2);
        check("full_rx_req", rx_req, 0);
        check("full_ovf_early", rx_ovf, 0);
        repeat (300) @(negedge clk);
        check("full_ovf_late", rx_ovf, 1);
        check("full_still_left", rx_q.size(), 2);
        set_ready(1'b1);
        for (int c = 0; c < 300 && rd_log.size() < n0 + 6; c++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("full_resume_count", rd_log.size() - n0, 6);
        for (int i = 0; i < 6; i++) begin
            got = (rd_log.size() > n0 + i) ? rd_log[n0 + i] : 8'hxx;
            check($sformatf("full_byte%0d", i), got, 32'(8'h61 + i));
        end
        check("full_ovf_sticky", rx_ovf, 1);

        // TX timeout: transmitter never drains
        stuck = 1'b1;
        @(negedge clk);
        a_req = 1'b1; a_data = 8'h55;
        done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (a_ack) begin
                a_req = 1'b0;
                done  = 1'b1;
                break;
            end
        end
        a_req = 1'b0;
        check("tmo_acked", done, 1);
        repeat (TX_TIMEOUT - 3) @(negedge clk);
        check("tmo_err_before", tx_err, 0);
        check("tmo_busy_before", tx_busy, 1);
        repeat (8) @(negedge clk);
        check("tmo_err_after", tx_err, 1);
        check("tmo_busy_after", tx_busy, 0);
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        v = '{1'b1, 8'h56, 1'b0, 8'h00, 8'h56, 1, 0};
        run_tx(v, "tmo_next");
        check("tmo_err_sticky", tx_err, 1);

        // Asynchronous reset in the middle of TX and RX activity
        set_ready(1'b0);
        stuck = 1'b1;
        rx_q.push_back(8'h71); rx_q.push_back(8'h72); rx_q.push_back(8'h73);
        @(negedge clk);
        a_req = 1'b1; a_data = 8'h77;
        for (int c = 0; c < 50 && !a_ack; c++) @(negedge clk);
        a_req = 1'b0;
        repeat (10) @(negedge clk);
        check("arst_pre_busy", tx_busy, 1);
        check("arst_pre_valid", rd_valid, 1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("arst");
        rx_q.delete();
        stuck = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_post_valid", rd_valid, 0);
        check("arst_post_err", tx_err, 0);
        check("arst_post_busy", tx_busy, 0);
        // Pointer was on B before reset; after reset A must win
        v = '{1'b1, 8'h5A, 1'b1, 8'h5B, 8'h5A, 1, 0};
        run_tx(v, "arst_rr");

        check("ack_pulse_width", max_run, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_ctl.md
Name: uart_ctl

Overview:
- Sequencing controller in front of the console UART (tx_req/tx_ack/tx_empty, rx_req/rx_ack/rx_empty/rx_data handshake).
- Arbitrates the single UART transmitter between two byte producers: port A (CPU TTY output) and port B (debug monitor).
- Polls the receiver autonomously and buffers received bytes in a small FIFO that feeds a valid/ready consumer.
- Flags a stuck transmitter with a timeout.

Parameters:
- RX_DEPTH, 4: receive FIFO entries; power of two, 2..16.
- TX_TIMEOUT, 1023: max cycles waiting for tx_empty after tx_ack before error; 16..65535.

Ports:
- clk  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous active-low reset
- a_req  in  1  port A has a byte; held until a_ack
- a_data  in  8  port A byte, stable while a_req
- a_ack  out  1  one-cycle pulse: port A byte accepted by UART
- b_req  in  1  port B request, same rules as A
- b_data  in  8  port B byte
- b_ack  out  1  one-cycle pulse for port B
- tx_req  out  1  to UART
- tx_data  out  8  to UART, stable while tx_req
- tx_ack  in  1  from UART
- tx_empty  in  1  from UART, high when transmitter idle
- rx_req  out  1  to UART
- rx_ack  in  1  from UART
- rx_empty  in  1  from UART, high when no byte pending
- rx_data  in  8  from UART
- rd_valid  out  1  FIFO non-empty
- rd_data  out  8  FIFO head
- rd_ready  in  1  consumer pop
- tx_busy  out  1  TX state machine not in T_IDLE
- tx_err  out  1  sticky timeout flag; cleared only by reset
- rx_ovf  out  1  sticky: FIFO full while rx_empty=0 for more than 255 consecutive cycles

Behaviour:
- Reset (async, reset_n=0): all outputs 0.
  - TX state = T_IDLE, RX state = R_IDLE.
  - FIFO pointers and count = 0, rr pointer = A, timeout counter = 0.
- TX FSM states: T_IDLE, T_REQ, T_SETTLE, T_BUSY.
  - T_IDLE: if a_req or b_req, choose grant and latch the grantee's data into tx_data; next state T_REQ.
  - Arbitration: if both request, grant the side rr points to. After each grant, rr points to the other side.
  - T_REQ: tx_req=1. When tx_ack=1, pulse the grantee's ack (a_ack or b_ack) in that same cycle; next state T_SETTLE.
  - T_SETTLE: one cycle, tx_empty ignored (UART updates empty one cycle after ack); next state T_BUSY.
  - T_BUSY: count cycles. When tx_empty=1, go to T_IDLE.
  - Timeout: if the count reaches TX_TIMEOUT, set tx_err and go to T_IDLE (byte considered lost).
  - Back-to-back throughput: minimum 4 cycles plus UART drain per byte.
  - A requester dropping req while not granted is legal. Dropping req while granted is illegal; the controller completes using the latched data.
- RX FSM states: R_IDLE, R_REQ, R_WAIT, R_CAP.
  - R_IDLE: if rx_empty=0 and FIFO count < RX_DEPTH, go to R_REQ.
  - R_REQ: rx_req=1 until rx_ack=1; next state R_WAIT.
  - R_WAIT: one cycle while the UART dispenses; next state R_CAP.
  - R_CAP: push rx_data into the FIFO at the edge ending this cycle; next state R_IDLE.
  - Reservation rule: the FIFO slot is reserved on entry to R_REQ, so the push can never overflow.
- FIFO: circular, log2(RX_DEPTH)-bit pointers that wrap.
  - rd_data = mem[rd_ptr], combinational from registers.
  - Pop when rd_valid && rd_ready.
  - Push and pop in the same cycle leave count unchanged; a push into an empty FIFO gives rd_valid=1 the next cycle.
  - Full: RX FSM stays in R_IDLE, leaving the byte in the UART. Stall counter runs while full && !rx_empty; at 255 it sets rx_ovf. Stall counter clears when not full.
- Reset mid-operation: the byte in flight is abandoned, nothing is replayed, and FIFO contents are discarded.
- TX and RX FSMs are fully independent; simultaneous activity is allowed.

Decomposition:
- Shared package uart_ctl_pkg:
  - TX state encodings T_IDLE=0, T_REQ=1, T_SETTLE=2, T_BUSY=3.
  - RX state encodings R_IDLE=0, R_REQ=1, R_WAIT=2, R_CAP=3.
  - Constant STALL_LIMIT=255.
- One sub-module, uart_ctl_fifo: parameterised RX_DEPTH x 8 FIFO with push, pop, full, count, valid and head outputs.
- Arbiter and both FSMs stay in uart_ctl.

Test Plan:
- Single A byte: a_req=1, a_data=8'h41 with the fake UART → tx_data=8'h41, tx_req until tx_ack; a_ack pulses exactly 1 cycle; tx_busy falls once tx_empty returns (~20 cycles later); b_ack stays 0.
- Contention: a_req and b_req held continuously with 3 bytes each → grants alternate A,B,A,B,A,B; 6 acks total; tx_data order 'A1','B1',...
- RX drain: UART preloaded with "START\r" (23-byte stream), rd_ready=1 → rd_data sequence 0x53,0x54,0x41,0x52,0x54,0x0D...; all 23 bytes received with no loss and no duplicates.
- FIFO full: rd_ready=0 → exactly RX_DEPTH=4 bytes captured, rx_req stays 0. After 255 cycles rx_ovf=1. Raising rd_ready resumes with byte 5 intact.
- TX timeout: tx_empty forced 0 after ack → tx_err=1 at cycle TX_TIMEOUT; FSM returns to T_IDLE; next a_req is still served.
- Async reset: reset_n pulsed low mid-transfer (T_BUSY, R_WAIT) → all outputs 0 immediately, without waiting for clk; FIFO empty; tx_err cleared.
